shift_tx: RTL and testbench
===========================

# shift_tx

Parallel-in, serial-out transmitter that feeds the team's serial-in shift register receiver. It accepts N-bit words over a valid/ready handshake and buffers one word in a holding register. It shifts each word out one bit per bit period, with a per-bit strobe that drives the receiver's `shift_en` directly. The word's direction bit selects MSB-first or LSB-first order, so the receiver rebuilds the original word when it runs with the same `dir`.

## Interface
- `N`, default 8: word width; legal N ≥ 2.
- `DIV`, default 1: clocks per bit period; legal DIV ≥ 1.

- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer offers `in_data`/`in_dir`.
- `in_ready`  out  1  holding register can accept a word.
- `in_data`  in  N  word to transmit.
- `in_dir`  in  1  0 = MSB first (pairs with receiver dir=0, left shift); 1 = LSB first (pairs with receiver dir=1, right shift).
- `ser_out`  out  1  serial data bit.
- `ser_valid`  out  1  high for every cycle of every bit period.
- `ser_strobe`  out  1  one-cycle pulse on the last clock of each bit period; connect to receiver `shift_en`.
- `frame_start`  out  1  pulse on the first clock of bit 0.
- `done`  out  1  pulse on the last clock of bit N-1, coincident with that bit's `ser_strobe`.

## Operation
- Storage:
  - holding register: data, dir, `hold_full`.
  - shifter: data, dir.
  - counters: `div_cnt` (0..DIV-1) and `bit_cnt` (0..N-1).
- FSM has two states, IDLE and SHIFT.
- Handshake:
  - A word transfers when `in_valid && in_ready` at a rising edge. `in_data` and `in_dir` are captured into the holding register and `hold_full` sets.
  - `in_ready` = !`hold_full` && !`rst`.
  - `in_dir` is ignored except at handshake. The direction stays fixed for the whole word.
- IDLE:
  - If `hold_full`, the holding register loads into the shifter at the next edge, `hold_full` clears, and the FSM enters SHIFT with both counters at 0.
  - Outputs: `ser_out`=0, `ser_valid`=0.
- SHIFT:
  - `ser_out` = shifter bit `N-1-bit_cnt` if dir=0, or bit `bit_cnt` if dir=1.
  - `ser_valid`=1.
  - `div_cnt` increments every cycle and wraps at DIV-1. At the wrap, `ser_strobe`=1 and `bit_cnt` increments.
- End of frame, i.e. the cycle with `bit_cnt`=N-1 and `div_cnt`=DIV-1:
  - `done`=1.
  - If `hold_full`, the next word loads at this edge and SHIFT continues with no idle cycle.
  - Otherwise the FSM returns to IDLE.
- Simultaneous events:
  - A handshake on the same edge as a shifter load from a previously full holding register is impossible, because `in_ready`=0 while the register is full.
  - A word accepted at the end-of-frame edge while the register is empty is not sent back-to-back. It waits in the holding register, IDLE lasts one cycle, then the word loads.
- Reset, whether asserted at any time or mid-frame:
  - The frame is aborted and the holding register is discarded (`hold_full`=0).
  - The FSM goes to IDLE and the counters to 0.
  - No `done` is generated for the aborted word.

## Timing
- Reset values: `ser_out`, `ser_valid`, `ser_strobe`, `frame_start` and `done` are all 0. `in_ready` is 0 while `rst`=1 and 1 in the first cycle after release.
- Latency from IDLE: handshake at edge E0, shifter load at E1, first bit (with `frame_start`) in the cycle after E1. This is 2 clocks from the accept edge to the first bit.
- Frame length is exactly N·DIV cycles of `ser_valid`.
- `in_ready` returns to 1 in the cycle after the shifter load. A streaming producer therefore refills the holding register during each frame and sustains gap-free output.
- All outputs are registered, or decoded from registered state with no path from inputs. The exception is `in_ready`, which depends only on state and `rst`.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles while driving `in_valid`=1 → all outputs 0 and `in_ready`=0 throughout; `in_ready`=1 in the first cycle after release.
- **MSB first (N=8, DIV=1):** send 8'hC1 with `in_dir`=0 → starting 2 cycles after the accept edge, `ser_out` = 1,1,0,0,0,0,0,1 on 8 consecutive cycles; `frame_start` on the first, `done` on the eighth. A looped-back receiver with `shift_en`=`ser_strobe` and `dir`=0 holds q_out=8'hC1.
- **LSB first:** send 8'hC1 with `in_dir`=1 → `ser_out` = 1,0,0,0,0,0,1,1. A receiver with `dir`=1 holds q_out=8'hC1.
- **Back-to-back:** hold `in_valid`=1 with words 8'h11, 8'h22, 8'h33 → 24 consecutive `ser_valid` cycles with no gap, 3 `done` pulses, and `in_ready` low while the holding register is full.
- **Bit period (DIV=3):** send 8'hC1 with `in_dir`=0 → each bit is held for 3 cycles, `ser_strobe` fires on the 3rd cycle of each bit, and the frame lasts 24 cycles.
- **Reset mid-frame:** assert `rst` during bit 3 with a second word waiting in the holding register → all outputs 0 in the next cycle, no `done`, and the pending word is never sent. After release, a new word 8'h5A transmits from bit 0 with correct latency.

Source files
------------

// File: rtl/shift_tx_if.sv
// Handshake and serial-side signals of the shift_tx transmitter, bundled so the
// producer/monitor (master) and the transmitter (slave) share one port.
interface shift_tx_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         in_dir;
    logic         ser_out;
    logic         ser_valid;
    logic         ser_strobe;
    logic         frame_start;
    logic         done;

    modport master (
        output in_valid,
        output in_data,
        output in_dir,
        input  in_ready,
        input  ser_out,
        input  ser_valid,
        input  ser_strobe,
        input  frame_start,
        input  done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_dir,
        output in_ready,
        output ser_out,
        output ser_valid,
        output ser_strobe,
        output frame_start,
        output done
    );
endinterface

// File: rtl/shift_tx.sv
// Parallel-in, serial-out transmitter: one-word holding register, DIV clocks per
// bit, MSB- or LSB-first per word, strobe on the last clock of every bit period.
module shift_tx #(
    parameter int N   = 8,
    parameter int DIV = 1
) (
    input  logic      clk,
    input  logic      rst,
    shift_tx_if.slave bus
);
    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int            BW       = $clog2(N);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [N-1:0]  hold_data_r;
    logic [N-1:0]  hold_data_nxt_s;
    logic          hold_dir_r;
    logic          hold_dir_nxt_s;
    logic          hold_full_r;
    logic          hold_full_nxt_s;
    logic [N-1:0]  sh_data_r;
    logic [N-1:0]  sh_data_nxt_s;
    logic          sh_dir_r;
    logic          sh_dir_nxt_s;
    logic [CW-1:0] div_cnt_r;
    logic [CW-1:0] div_cnt_nxt_s;
    logic [BW-1:0] bit_cnt_r;
    logic [BW-1:0] bit_cnt_nxt_s;
    logic          load_s;
    logic          accept_s;
    logic          in_ready_s;

    logic          ser_out_r;
    logic          ser_out_nxt_s;
    logic          ser_valid_r;
    logic          ser_valid_nxt_s;
    logic          ser_strobe_r;
    logic          ser_strobe_nxt_s;
    logic          frame_start_r;
    logic          frame_start_nxt_s;
    logic          done_r;
    logic          done_nxt_s;

    // Bit of the word that goes on the line for bit slot idx.
    function automatic logic pick_bit(input logic [N-1:0] data,
                                      input logic         lsb_first,
                                      input logic [BW-1:0] idx);
        logic [BW-1:0] ridx;
        ridx = BIT_LAST - idx;
        return lsb_first ? data[idx] : data[ridx];
    endfunction

    assign in_ready_s      = ~hold_full_r & ~rst;
    assign accept_s        = bus.in_valid & in_ready_s;
    assign bus.in_ready    = in_ready_s;
    assign bus.ser_out     = ser_out_r;
    assign bus.ser_valid   = ser_valid_r;
    assign bus.ser_strobe  = ser_strobe_r;
    assign bus.frame_start = frame_start_r;
    assign bus.done        = done_r;

    // FSM next state and bit/period counters; load_s moves the holding word into the shifter.
    always_comb begin
        state_nxt_s   = state_r;
        div_cnt_nxt_s = div_cnt_r;
        bit_cnt_nxt_s = bit_cnt_r;
        load_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (hold_full_r) begin
                    load_s        = 1'b1;
                    state_nxt_s   = SHIFT;
                    div_cnt_nxt_s = '0;
                    bit_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            SHIFT: begin
                if (div_cnt_r == DIV_LAST) begin
                    div_cnt_nxt_s = '0;
                    if (bit_cnt_r == BIT_LAST) begin
                        bit_cnt_nxt_s = '0;
                        // A word already waiting follows with no idle cycle.
                        if (hold_full_r) begin
                            load_s      = 1'b1;
                            state_nxt_s = SHIFT;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + BW'(1);
                    end
                end else begin
                    div_cnt_nxt_s = div_cnt_r + CW'(1);
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                div_cnt_nxt_s = '0;
                bit_cnt_nxt_s = '0;
            end
        endcase
    end

    // Holding register: cleared by a load, filled by a handshake (never both at once).
    always_comb begin
        hold_full_nxt_s = hold_full_r;
        hold_data_nxt_s = hold_data_r;
        hold_dir_nxt_s  = hold_dir_r;
        if (load_s) begin
            hold_full_nxt_s = 1'b0;
        end else if (accept_s) begin
            hold_full_nxt_s = 1'b1;
            hold_data_nxt_s = bus.in_data;
            hold_dir_nxt_s  = bus.in_dir;
        end else begin
            hold_full_nxt_s = hold_full_r;
        end
    end

    // Shifter contents change only on a load; the direction is frozen for the whole word.
    always_comb begin
        sh_data_nxt_s = sh_data_r;
        sh_dir_nxt_s  = sh_dir_r;
        if (load_s) begin
            sh_data_nxt_s = hold_data_r;
            sh_dir_nxt_s  = hold_dir_r;
        end else begin
            sh_data_nxt_s = sh_data_r;
            sh_dir_nxt_s  = sh_dir_r;
        end
    end

    // Output values for the coming cycle, decoded from next state so the outputs can be registered.
    always_comb begin
        ser_out_nxt_s     = 1'b0;
        ser_valid_nxt_s   = 1'b0;
        ser_strobe_nxt_s  = 1'b0;
        frame_start_nxt_s = 1'b0;
        done_nxt_s        = 1'b0;
        if (state_nxt_s == SHIFT) begin
            ser_valid_nxt_s   = 1'b1;
            ser_out_nxt_s     = pick_bit(sh_data_nxt_s, sh_dir_nxt_s, bit_cnt_nxt_s);
            ser_strobe_nxt_s  = (div_cnt_nxt_s == DIV_LAST);
            frame_start_nxt_s = (bit_cnt_nxt_s == '0) && (div_cnt_nxt_s == '0);
            done_nxt_s        = (bit_cnt_nxt_s == BIT_LAST) && (div_cnt_nxt_s == DIV_LAST);
        end else begin
            ser_valid_nxt_s   = 1'b0;
        end
    end

    // State, storage and output registers; reset aborts the frame and discards the held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            hold_full_r   <= 1'b0;
            hold_data_r   <= '0;
            hold_dir_r    <= 1'b0;
            sh_data_r     <= '0;
            sh_dir_r      <= 1'b0;
            div_cnt_r     <= '0;
            bit_cnt_r     <= '0;
            ser_out_r     <= 1'b0;
            ser_valid_r   <= 1'b0;
            ser_strobe_r  <= 1'b0;
            frame_start_r <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            hold_full_r   <= hold_full_nxt_s;
            hold_data_r   <= hold_data_nxt_s;
            hold_dir_r    <= hold_dir_nxt_s;
            sh_data_r     <= sh_data_nxt_s;
            sh_dir_r      <= sh_dir_nxt_s;
            div_cnt_r     <= div_cnt_nxt_s;
            bit_cnt_r     <= bit_cnt_nxt_s;
            ser_out_r     <= ser_out_nxt_s;
            ser_valid_r   <= ser_valid_nxt_s;
            ser_strobe_r  <= ser_strobe_nxt_s;
            frame_start_r <= frame_start_nxt_s;
            done_r        <= done_nxt_s;
        end
    end
endmodule

// File: tb/tb_shift_tx.sv
// Self-checking bench for shift_tx: two instances (DIV=1 and DIV=3), a frame-level
// reference model of the serial stream and a behavioural shift-register receiver.
module tb_shift_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [1:0]      drv_valid = 2'b00;
    logic [1:0][7:0] drv_data  = '0;
    logic [1:0]      drv_dir   = 2'b00;
    logic [1:0]      obs_rdy, obs_so, obs_sv, obs_st, obs_fs, obs_dn;

    shift_tx_if #(.N(8)) if1 ();
    shift_tx_if #(.N(8)) if3 ();

    shift_tx #(.N(8), .DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    shift_tx #(.N(8), .DIV(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    assign if1.in_valid = drv_valid[0];
    assign if1.in_data  = drv_data[0];
    assign if1.in_dir   = drv_dir[0];
    assign if3.in_valid = drv_valid[1];
    assign if3.in_data  = drv_data[1];
    assign if3.in_dir   = drv_dir[1];
    assign obs_rdy = {if3.in_ready,    if1.in_ready};
    assign obs_so  = {if3.ser_out,     if1.ser_out};
    assign obs_sv  = {if3.ser_valid,   if1.ser_valid};
    assign obs_st  = {if3.ser_strobe,  if1.ser_strobe};
    assign obs_fs  = {if3.frame_start, if1.frame_start};
    assign obs_dn  = {if3.done,        if1.done};

    always #5 clk = ~clk;

    // Expected serial timeline: idle cycle after accept, then frames back to back, then idle.
    function automatic void model_stream(input logic [7:0] w [3], input logic dr [3],
                                         input int nw, input int div,
                                         output logic [127:0] so, output logic [127:0] sv,
                                         output logic [127:0] st, output logic [127:0] fs,
                                         output logic [127:0] dn);
        int t;
        so = '0; sv = '0; st = '0; fs = '0; dn = '0;
        t = 1;
        for (int f = 0; f < nw; f++)
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < div; c++) begin
                    sv[t] = 1'b1;
                    so[t] = dr[f] ? w[f][b] : w[f][7-b];
                    st[t] = (c == div - 1);
                    fs[t] = (b == 0) && (c == 0);
                    dn[t] = (b == 7) && (c == div - 1);
                    t++;
                end
    endfunction

    // Offer nw words as fast as in_ready allows and compare the whole observed timeline.
    task automatic run_stream(input int sel, input int div, input int nw,
                              input logic [7:0] w [3], input logic dr [3], input string name,
                              output int nvalid, output int ndone);
        logic [127:0] so_o, sv_o, st_o, fs_o, dn_o, rd_o;
        logic [127:0] so_e, sv_e, st_e, fs_e, dn_e, rd_e;
        logic [7:0]   rx;
        logic [7:0]   rxq [$];
        int len, guard, f;
        len = 2 + nw * 8 * div;
        so_o = '0; sv_o = '0; st_o = '0; fs_o = '0; dn_o = '0; rd_o = '0;
        model_stream(w, dr, nw, div, so_e, sv_e, st_e, fs_e, dn_e);
        rd_e = '0;
        for (int t = 0; t < len; t++) begin
            if (t >= 1 + (nw - 1) * 8 * div) rd_e[t] = 1'b1;
            for (int k = 0; k < nw; k++)
                if (t == 1 + k * 8 * div) rd_e[t] = 1'b1;
        end
        fork
            begin
                for (int k = 0; k < nw; k++) begin
                    drv_valid[sel] = 1'b1;
                    drv_data[sel]  = w[k];
                    drv_dir[sel]   = dr[k];
                    guard = 0;
                    while (obs_rdy[sel] !== 1'b1 && guard < 200) begin
                        @(negedge clk);
                        guard++;
                    end
                    checks++;
                    if (guard >= 200) begin
                        errors++;
                        $display("FAIL %s accept_timeout word %0d: in_ready=%b, required 1", name, k, obs_rdy[sel]);
                    end
                    @(negedge clk);
                end
                drv_valid[sel] = 1'b0;
            end
            begin
                for (int t = 0; t < len; t++) begin
                    @(negedge clk);
                    so_o[t] = obs_so[sel];
                    sv_o[t] = obs_sv[sel];
                    st_o[t] = obs_st[sel];
                    fs_o[t] = obs_fs[sel];
                    dn_o[t] = obs_dn[sel];
                    rd_o[t] = obs_rdy[sel];
                end
            end
        join
        checks++; if (sv_o !== sv_e) begin errors++; $display("FAIL %s ser_valid got %h expected %h", name, sv_o, sv_e); end
        checks++; if (so_o !== so_e) begin errors++; $display("FAIL %s ser_out got %h expected %h", name, so_o, so_e); end
        checks++; if (st_o !== st_e) begin errors++; $display("FAIL %s ser_strobe got %h expected %h", name, st_o, st_e); end
        checks++; if (fs_o !== fs_e) begin errors++; $display("FAIL %s frame_start got %h expected %h", name, fs_o, fs_e); end
        checks++; if (dn_o !== dn_e) begin errors++; $display("FAIL %s done got %h expected %h", name, dn_o, dn_e); end
        checks++; if (rd_o !== rd_e) begin errors++; $display("FAIL %s in_ready got %h expected %h", name, rd_o, rd_e); end
        // Looped-back receiver: shift on each strobe, word complete on done.
        rx = '0;
        f = 0;
        for (int t = 0; t < len; t++)
            if (st_o[t] === 1'b1) begin
                rx = dr[f] ? {so_o[t], rx[7:1]} : {rx[6:0], so_o[t]};
                if (dn_o[t] === 1'b1) begin
                    rxq.push_back(rx);
                    if (f < nw - 1) f++;
                end
            end
        checks++;
        if (rxq.size() != nw) begin
            errors++;
            $display("FAIL %s rx_count got %0d expected %0d", name, rxq.size(), nw);
        end else begin
            for (int k = 0; k < nw; k++) begin
                checks++;
                if (rxq[k] !== w[k]) begin
                    errors++;
                    $display("FAIL %s rx_word %0d got %h expected %h", name, k, rxq[k], w[k]);
                end
            end
        end
        nvalid = 0;
        ndone  = 0;
        for (int t = 0; t < len; t++) begin
            if (sv_o[t] === 1'b1) nvalid++;
            if (dn_o[t] === 1'b1) ndone++;
        end
    endtask

    task automatic test_reset();
        drv_valid = 2'b11;
        drv_data  = {8'hA5, 8'h3C};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({obs_so, obs_sv, obs_st, obs_fs, obs_dn, obs_rdy} !== 12'h000) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d got %h expected 000", i,
                         {obs_so, obs_sv, obs_st, obs_fs, obs_dn, obs_rdy});
            end
        end
        rst = 1'b0;
        drv_valid = 2'b00;
        #1;
        checks++;
        if (obs_rdy !== 2'b11) begin errors++; $display("FAIL reset_release in_ready got %b expected 11", obs_rdy); end
        @(negedge clk);
        checks++;
        if ({obs_so, obs_sv, obs_st, obs_fs, obs_dn, obs_rdy} !== 12'h003) begin
            errors++;
            $display("FAIL reset_idle got %h expected 003", {obs_so, obs_sv, obs_st, obs_fs, obs_dn, obs_rdy});
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] w [3];
        logic       dr [3];
        int nv, nd;
        w  = '{8'hC1, 8'h00, 8'h00};
        dr = '{1'b0, 1'b0, 1'b0};
        run_stream(0, 1, 1, w, dr, "msb_first", nv, nd);
    endtask

    task automatic test_lsb_first();
        logic [7:0] w [3];
        logic       dr [3];
        int nv, nd;
        w  = '{8'hC1, 8'h00, 8'h00};
        dr = '{1'b1, 1'b1, 1'b1};
        run_stream(0, 1, 1, w, dr, "lsb_first", nv, nd);
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [3];
        logic       dr [3];
        int nv, nd;
        w  = '{8'h11, 8'h22, 8'h33};
        dr = '{1'b0, 1'b0, 1'b0};
        run_stream(0, 1, 3, w, dr, "back_to_back", nv, nd);
        checks++; if (nv != 24) begin errors++; $display("FAIL back_to_back valid_cycles got %0d expected 24", nv); end
        checks++; if (nd != 3)  begin errors++; $display("FAIL back_to_back done_pulses got %0d expected 3", nd); end
    endtask

    task automatic test_bit_period();
        logic [7:0] w [3];
        logic       dr [3];
        int nv, nd;
        w  = '{8'hC1, 8'h00, 8'h00};
        dr = '{1'b0, 1'b0, 1'b0};
        run_stream(1, 3, 1, w, dr, "bit_period", nv, nd);
        checks++; if (nv != 24) begin errors++; $display("FAIL bit_period frame_cycles got %0d expected 24", nv); end
    endtask

    task automatic test_random();
        logic [7:0] w [3];
        logic       dr [3];
        int nv, nd, sel, nw;
        for (int it = 0; it < 8; it++) begin
            sel = it % 2;
            nw  = $urandom_range(1, 3);
            for (int k = 0; k < 3; k++) begin
                w[k]  = 8'($urandom);
                dr[k] = 1'($urandom);
            end
            run_stream(sel, (sel == 1) ? 3 : 1, nw, w, dr, "random", nv, nd);
            checks++; if (nd != nw) begin errors++; $display("FAIL random done_pulses got %0d expected %0d", nd, nw); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] wa, wb;
        logic [7:0] w [3];
        logic       dr [3];
        logic       bad;
        int nv, nd;
        wa = 8'($urandom);
        wb = 8'($urandom);
        drv_valid[0] = 1'b1; drv_data[0] = wa; drv_dir[0] = 1'b0;
        @(negedge clk);
        drv_data[0] = wb;
        @(negedge clk);
        checks++;
        if (obs_fs[0] !== 1'b1 || obs_rdy[0] !== 1'b1) begin
            errors++; $display("FAIL mid_first_bit frame_start=%b in_ready=%b expected 1 1", obs_fs[0], obs_rdy[0]);
        end
        @(negedge clk);
        drv_valid[0] = 1'b0;
        checks++;
        if (obs_rdy[0] !== 1'b0) begin errors++; $display("FAIL mid_hold_full in_ready got %b expected 0", obs_rdy[0]); end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs_so[0] !== wa[4] || obs_sv[0] !== 1'b1) begin
            errors++; $display("FAIL mid_bit3 ser_out=%b ser_valid=%b expected %b 1", obs_so[0], obs_sv[0], wa[4]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({obs_so[0], obs_sv[0], obs_st[0], obs_fs[0], obs_dn[0], obs_rdy[0]} !== 6'b000000) begin
            errors++; $display("FAIL mid_reset_outputs got %b expected 000000",
                               {obs_so[0], obs_sv[0], obs_st[0], obs_fs[0], obs_dn[0], obs_rdy[0]});
        end
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (obs_sv[0] !== 1'b0 || obs_dn[0] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL mid_pending_discarded activity seen=%b expected 0", bad); end
        w  = '{8'h5A, 8'h00, 8'h00};
        dr = '{1'($urandom), 1'b0, 1'b0};
        run_stream(0, 1, 1, w, dr, "mid_restart", nv, nd);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_bit_period();
        test_random();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
